// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the two-port SRAM arbiter:
//   - state_t   : arbiter FSM states (IDLE, ACCESS, COMPLETE)
//   - PORT_IF   : port ID of the instruction-fetch requester
//   - PORT_DM   : port ID of the data-memory requester
//   - rr_pick() : round-robin tie-break helper (grants the port not granted last)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // On a tie, hand the SRAM to whichever port did not get the previous grant.
  function automatic logic rr_pick(input logic last_grant);
    return (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-ported SRAM between an instruction-fetch read port
//   (if_*) and a data-memory read/write port (dm_*). Each transaction is
//   IDLE -> ACCESS (WAIT_CYCLES cycles) -> COMPLETE (one-cycle ack).
//
// Parameters
//   WAIT_CYCLES : SRAM access cycles per transaction, 1..15
//   ADDR_W      : address width
//   DATA_W      : data width
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   if_req/if_addr      : fetch request (held until if_ack) and address
//   if_ack/if_rdata     : fetch completion pulse and read data
//   dm_req/dm_we        : data request (held until dm_ack), 1 = write
//   dm_addr/dm_wdata    : data address and write data
//   dm_ack/dm_rdata     : data completion pulse and read data
//   sram_cs/oe/we       : SRAM strobes, active-high, only asserted in ACCESS
//   sram_addr/sram_din  : SRAM address / write data (hold last latched values)
//   sram_dout           : SRAM read data, captured unchanged bit-for-bit
//   busy                : high whenever the FSM is not in IDLE
//
// Configuration
//   SRAM_ARB_RR_EN undefined : fixed priority, dm wins every tie
//   SRAM_ARB_RR_EN defined   : round robin; the first tie after reset goes to dm
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 1..15");
  end

  // The down-counter starts at WAIT_CYCLES-1 and the access ends when it
  // reads zero, so ACCESS lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              winner;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] din_l;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] dm_rdata_r;

  logic              grant;
  logic              grant_port;
  logic              tie_port;

  // Tie-break policy
`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_IF;
    end else if (grant) begin
      last_grant <= grant_port;
    end
  end

  assign tie_port = rr_pick(last_grant);
`else
  assign tie_port = PORT_DM;
`endif

  assign grant = (state == IDLE) && (if_req || dm_req);

  always_comb begin
    grant_port = PORT_IF;
    if (if_req && dm_req) begin
      grant_port = tie_port;
    end else if (dm_req) begin
      grant_port = PORT_DM;
    end
  end

  // Control: FSM, access counter, latched winner and direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      winner <= PORT_IF;
      we_l   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state  <= ACCESS;
            cnt    <= CNT_LOAD;
            winner <= grant_port;
            we_l   <= (grant_port == PORT_DM) && dm_we;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= COMPLETE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        COMPLETE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: request latches at grant, read capture on the last ACCESS cycle.
  // Only the dm port carries write data, so sram_din only reloads on dm grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_l     <= '0;
      din_l      <= '0;
      if_rdata_r <= '0;
      dm_rdata_r <= '0;
    end else begin
      if (grant) begin
        if (grant_port == PORT_DM) begin
          addr_l <= dm_addr;
          din_l  <= dm_wdata;
        end else begin
          addr_l <= if_addr;
        end
      end
      if ((state == ACCESS) && (cnt == 4'd0) && !we_l) begin
        if (winner == PORT_IF) begin
          if_rdata_r <= sram_dout;
        end else begin
          dm_rdata_r <= sram_dout;
        end
      end
    end
  end

  // Outputs decode directly from state so a reset drops them immediately.
  assign sram_cs   = (state == ACCESS);
  assign sram_oe   = sram_cs && !we_l;
  assign sram_we   = sram_cs && we_l;
  assign sram_addr = addr_l;
  assign sram_din  = din_l;

  assign if_ack    = (state == COMPLETE) && (winner == PORT_IF);
  assign dm_ack    = (state == COMPLETE) && (winner == PORT_DM);
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter. Two instances: u_dut (WAIT_CYCLES=1)
//   for the functional scenarios and u_dut3 (WAIT_CYCLES=3) for reset abort.
//   A scoreboard queue holds expected completions in grant order; a monitor
//   pops and compares on every ack.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst3_n;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_ack, dm_ack, sram_cs, sram_oe, sram_we, busy;
  logic [31:0] if_rdata, dm_rdata, sram_addr, sram_din, sram_dout;

  logic        d3_if_req, d3_dm_req, d3_dm_we;
  logic [31:0] d3_if_addr, d3_dm_addr, d3_dm_wdata;
  logic        d3_if_ack, d3_dm_ack, d3_cs, d3_oe, d3_we, d3_busy;
  logic [31:0] d3_if_rdata, d3_dm_rdata, d3_sram_addr, d3_sram_din, d3_sram_dout;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_if_rd;
  logic [31:0] exp_dm_rd;
`ifdef SRAM_ARB_RR_EN
  logic        model_last;
`endif

  always #5 clk = ~clk;

  // SRAM contents model: one fixed word, everything else derived from address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h00400020) return 32'h2001AAAA;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign sram_dout    = mem_val(sram_addr);
  assign d3_sram_dout = mem_val(d3_sram_addr);

  sram_arbiter #(.WAIT_CYCLES(W1), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(W3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(d3_if_req), .if_addr(d3_if_addr), .if_ack(d3_if_ack), .if_rdata(d3_if_rdata),
    .dm_req(d3_dm_req), .dm_we(d3_dm_we), .dm_addr(d3_dm_addr), .dm_wdata(d3_dm_wdata),
    .dm_ack(d3_dm_ack), .dm_rdata(d3_dm_rdata),
    .sram_cs(d3_cs), .sram_oe(d3_oe), .sram_we(d3_we),
    .sram_addr(d3_sram_addr), .sram_din(d3_sram_din), .sram_dout(d3_sram_dout),
    .busy(d3_busy)
  );

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (if_ack || dm_ack)) begin
      total++;
      if (if_ack && dm_ack) begin
        bad++;
        $display("FAIL dual_ack: got if_ack=1 dm_ack=1, expected one ack");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b, expected none", if_ack, dm_ack);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.port == PORT_IF) begin
          if (!if_ack || if_rdata !== mon_e.data) begin
            bad++;
            $display("FAIL sb_if: got if_ack=%0b if_rdata=%h, expected if_ack=1 if_rdata=%h",
                     if_ack, if_rdata, mon_e.data);
          end
        end else begin
          if (!dm_ack || dm_rdata !== mon_e.data) begin
            bad++;
            $display("FAIL sb_dm: got dm_ack=%0b dm_rdata=%h, expected dm_ack=1 dm_rdata=%h (we=%0b)",
                     dm_ack, dm_rdata, mon_e.data, mon_e.we);
          end
        end
      end
    end
  end

  task automatic push_txn(input logic port, input logic we, input logic [31:0] addr);
    exp_t e;
    e.port = port;
    e.we   = we;
    if (we) begin
      e.data = exp_dm_rd;
    end else begin
      e.data = mem_val(addr);
      if (port == PORT_IF) exp_if_rd = e.data;
      else                 exp_dm_rd = e.data;
    end
`ifdef SRAM_ARB_RR_EN
    model_last = port;
`endif
    sb.push_back(e);
  endtask

  // Waits for the given port's ack; n = negedge index of the ack (1 = the
  // cycle the request was first presented), plus strobe cycle counts.
  task automatic wait_ack(input logic port, input string tag, output int n,
                          output int cs_n, output int oe_n, output int we_n);
    n = 0; cs_n = 0; oe_n = 0; we_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sram_cs) cs_n++;
      if (sram_oe) oe_n++;
      if (sram_we) we_n++;
      if ((port == PORT_IF) ? if_ack : dm_ack) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL %s_ack_timeout: got no ack, expected ack within 100 cycles", tag);
    end
  endtask

  task automatic if_port(input int k, input logic [31:0] base);
    int n, a, b, c;
    for (int i = 0; i < k; i++) begin
      if_addr = base + 32'(4 * i);
      if_req  = 1'b1;
      wait_ack(PORT_IF, "if_port", n, a, b, c);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
  endtask

  task automatic dm_port(input int k, input logic [31:0] base, input logic we);
    int n, a, b, c;
    for (int i = 0; i < k; i++) begin
      dm_addr  = base + 32'(4 * i);
      dm_we    = we;
      dm_wdata = 32'hC0DE0000 + 32'(i);
      dm_req   = 1'b1;
      wait_ack(PORT_DM, "dm_port", n, a, b, c);
      @(posedge clk); #1;
    end
    dm_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    d3_if_req = 0; d3_if_addr = 0; d3_dm_req = 0; d3_dm_we = 0; d3_dm_addr = 0; d3_dm_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({if_ack, dm_ack} !== 2'b00) begin bad++; $display("FAIL rst_acks: got %b expected 00", {if_ack, dm_ack}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++; if ({sram_cs, sram_oe, sram_we} !== 3'b000) begin bad++; $display("FAIL rst_strobes: got %b expected 000", {sram_cs, sram_oe, sram_we}); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL rst_if_rdata: got %h expected 0", if_rdata); end
    total++; if (dm_rdata !== 32'h0) begin bad++; $display("FAIL rst_dm_rdata: got %h expected 0", dm_rdata); end
    total++; if (sram_addr !== 32'h0) begin bad++; $display("FAIL rst_sram_addr: got %h expected 0", sram_addr); end
    total++; if (sram_din !== 32'h0) begin bad++; $display("FAIL rst_sram_din: got %h expected 0", sram_din); end
    @(posedge clk); #1;
    rst_n = 1'b1; rst3_n = 1'b1;
    exp_if_rd = 32'h0; exp_dm_rd = 32'h0;
`ifdef SRAM_ARB_RR_EN
    model_last = PORT_IF;
`endif
  endtask

  task automatic test_if_read;
    int n, cs_n, oe_n, we_n;
    push_txn(PORT_IF, 1'b0, 32'h00400020);
    if_addr = 32'h00400020;
    if_req  = 1'b1;
    wait_ack(PORT_IF, "if_read", n, cs_n, oe_n, we_n);
    total++; if (n !== W1 + 2) begin bad++; $display("FAIL if_read_latency: got %0d expected %0d", n, W1 + 2); end
    total++; if (cs_n !== W1 || oe_n !== W1 || we_n !== 0) begin
      bad++; $display("FAIL if_read_strobes: got cs=%0d oe=%0d we=%0d expected %0d %0d 0", cs_n, oe_n, we_n, W1, W1);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    total++; if (sram_addr !== 32'h00400020) begin bad++; $display("FAIL addr_hold: got %h expected 00400020", sram_addr); end
  endtask

  task automatic test_dm_write;
    int n, cs_n, oe_n, we_n;
    push_txn(PORT_DM, 1'b0, 32'h00400040);
    dm_port(1, 32'h00400040, 1'b0);
    push_txn(PORT_DM, 1'b1, 32'h00400024);
    dm_addr  = 32'h00400024;
    dm_wdata = 32'h00220826;
    dm_we    = 1'b1;
    dm_req   = 1'b1;
    wait_ack(PORT_DM, "dm_write", n, cs_n, oe_n, we_n);
    total++; if (cs_n !== W1 || we_n !== W1 || oe_n !== 0) begin
      bad++; $display("FAIL dm_write_strobes: got cs=%0d we=%0d oe=%0d expected %0d %0d 0", cs_n, we_n, oe_n, W1, W1);
    end
    total++; if (sram_din !== 32'h00220826) begin bad++; $display("FAIL dm_write_din: got %h expected 00220826", sram_din); end
    total++; if (dm_rdata !== mem_val(32'h00400040)) begin
      bad++; $display("FAIL dm_write_rdata_hold: got %h expected %h", dm_rdata, mem_val(32'h00400040));
    end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic test_tie(input int k);
    int  ri, rd, ii, id;
    logic win;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_if_rd = 32'h0; exp_dm_rd = 32'h0;
`ifdef SRAM_ARB_RR_EN
    model_last = PORT_IF;
`endif
    ri = k; rd = k; ii = 0; id = 0;
    while (ri > 0 || rd > 0) begin
      if (ri > 0 && rd > 0) begin
`ifdef SRAM_ARB_RR_EN
        win = (model_last == PORT_IF) ? PORT_DM : PORT_IF;
`else
        win = PORT_DM;
`endif
      end else begin
        win = (rd > 0) ? PORT_DM : PORT_IF;
      end
      if (win == PORT_DM) begin
        push_txn(PORT_DM, 1'b0, 32'h00400200 + 32'(4 * id)); id++; rd--;
      end else begin
        push_txn(PORT_IF, 1'b0, 32'h00400100 + 32'(4 * ii)); ii++; ri--;
      end
    end
    fork
      if_port(k, 32'h00400100);
      dm_port(k, 32'h00400200, 1'b0);
    join
  endtask

  task automatic test_back_to_back;
    int n1, n2, a, b, c;
    push_txn(PORT_IF, 1'b0, 32'h00400028);
    push_txn(PORT_IF, 1'b0, 32'h0040002C);
    if_addr = 32'h00400028;
    if_req  = 1'b1;
    wait_ack(PORT_IF, "b2b_first", n1, a, b, c);
    @(posedge clk); #1;
    if_addr = 32'h0040002C;
    wait_ack(PORT_IF, "b2b_second", n2, a, b, c);
    @(posedge clk); #1;
    if_req = 1'b0;
    total++; if (n1 !== W1 + 2) begin bad++; $display("FAIL b2b_first_latency: got %0d expected %0d", n1, W1 + 2); end
    total++; if (n2 !== W1 + 2) begin bad++; $display("FAIL b2b_spacing: got %0d expected %0d", n2, W1 + 2); end
  endtask

  task automatic test_reset_abort;
    int n;
    d3_dm_addr = 32'h00400030;
    d3_dm_we   = 1'b0;
    d3_dm_req  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (d3_cs !== 1'b1) begin bad++; $display("FAIL abort_in_access: got cs=%b expected 1", d3_cs); end
    rst3_n = 1'b0;
    #1;
    total++; if ({d3_cs, d3_oe, d3_we, d3_busy} !== 4'b0000) begin
      bad++; $display("FAIL abort_drop: got cs/oe/we/busy=%b expected 0000", {d3_cs, d3_oe, d3_we, d3_busy});
    end
    total++; if ({d3_dm_ack, d3_if_ack} !== 2'b00) begin bad++; $display("FAIL abort_ack: got %b expected 00", {d3_dm_ack, d3_if_ack}); end
    @(posedge clk); #1;
    rst3_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (d3_dm_ack) begin n = i; break; end
    end
    total++; if (n !== W3 + 2) begin bad++; $display("FAIL abort_reissue_latency: got %0d expected %0d", n, W3 + 2); end
    total++; if (d3_dm_rdata !== mem_val(32'h00400030)) begin
      bad++; $display("FAIL abort_reissue_data: got %h expected %h", d3_dm_rdata, mem_val(32'h00400030));
    end
    @(posedge clk); #1;
    d3_dm_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_dm_write;
    test_back_to_back;
    test_reset_abort;
    test_tie(1);
    test_tie(2);
    repeat (2) @(posedge clk);
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
